// File: rtl/vga_timing_counter_if.sv
// Interface bundling the enable input and the timing outputs of
// vga_timing_counter. The counter drives through the master modport; the
// sync decoder / consumer uses the slave modport.
// Optional feature macro: FRAME_COUNT_EN adds the 8-bit o_frame_count.
interface vga_timing_counter_if #(
    parameter int HMAX = 800,
    parameter int VMAX = 525
);
    localparam int HW = (HMAX > 1) ? $clog2(HMAX) : 1;
    localparam int VW = (VMAX > 1) ? $clog2(VMAX) : 1;

    logic          i_Enable;
    logic [HW-1:0] o_H_count;
    logic [VW-1:0] o_V_count;
    logic          o_pix_tick;
    logic          o_line_end;
    logic          o_frame_end;
`ifdef FRAME_COUNT_EN
    logic [7:0]    o_frame_count;

    modport master (
        input  i_Enable,
        output o_H_count, o_V_count, o_pix_tick, o_line_end, o_frame_end,
        output o_frame_count
    );
    modport slave (
        output i_Enable,
        input  o_H_count, o_V_count, o_pix_tick, o_line_end, o_frame_end,
        input  o_frame_count
    );
`else
    modport master (
        input  i_Enable,
        output o_H_count, o_V_count, o_pix_tick, o_line_end, o_frame_end
    );
    modport slave (
        output i_Enable,
        input  o_H_count, o_V_count, o_pix_tick, o_line_end, o_frame_end
    );
`endif
endinterface

// File: rtl/vga_timing_counter.sv
// VGA raster timing counter: a pixel-rate divider feeding a horizontal
// column counter and a vertical line counter, with registered one-cycle
// pulses for each new pixel, each line wrap and each frame wrap.
// Optional feature macro: FRAME_COUNT_EN adds an 8-bit wrapping frame counter.
module vga_timing_counter #(
    parameter int HMAX           = 800,
    parameter int VMAX           = 525,
    parameter int CLKS_PER_PIXEL = 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    vga_timing_counter_if.master  tim
);
    localparam int HW = (HMAX > 1) ? $clog2(HMAX) : 1;
    localparam int VW = (VMAX > 1) ? $clog2(VMAX) : 1;
    localparam int DW = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(HMAX - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(VMAX - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_PIXEL - 1);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          pix_tick_q, pix_tick_d;
    logic          line_end_q, line_end_d;
    logic          frame_end_q, frame_end_d;
    logic          advance;
    logic          h_wrap;
    logic          v_wrap;
`ifdef FRAME_COUNT_EN
    logic [7:0]    frame_count_q, frame_count_d;
`endif

    // Next-state logic: divider, raster counters and the pulses that
    // describe the transition being taken on this edge.
    always_comb begin
        div_d       = div_q;
        h_d         = h_q;
        v_d         = v_q;
        advance     = 1'b0;
        h_wrap      = 1'b0;
        v_wrap      = 1'b0;
        pix_tick_d  = 1'b0;
        line_end_d  = 1'b0;
        frame_end_d = 1'b0;

        if (tim.i_Enable) begin
            // The divider only moves while enabled, so a paused pixel resumes
            // exactly where it stopped.
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                advance = 1'b1;
            end else begin
                div_d = div_q + DW'(1);
            end
        end

        if (advance) begin
            h_wrap = (h_q == H_LAST);
            v_wrap = h_wrap && (v_q == V_LAST);
            h_d    = h_wrap ? '0 : h_q + HW'(1);
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + VW'(1);
            end
        end

        pix_tick_d  = advance;
        line_end_d  = h_wrap;
        frame_end_d = v_wrap;
    end

`ifdef FRAME_COUNT_EN
    // Frame counter advances on the same edge that raises o_frame_end.
    always_comb begin
        frame_count_d = frame_count_q;
        if (frame_end_d) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end
`endif

    // State register; reset wins over enable and clears every pulse.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            div_q       <= '0;
            h_q         <= '0;
            v_q         <= '0;
            pix_tick_q  <= 1'b0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            h_q         <= h_d;
            v_q         <= v_d;
            pix_tick_q  <= pix_tick_d;
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
        end
    end

`ifdef FRAME_COUNT_EN
    // Frame counter register.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            frame_count_q <= 8'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign tim.o_frame_count = frame_count_q;
`endif

    assign tim.o_H_count   = h_q;
    assign tim.o_V_count   = v_q;
    assign tim.o_pix_tick  = pix_tick_q;
    assign tim.o_line_end  = line_end_q;
    assign tim.o_frame_end = frame_end_q;

endmodule

// File: doc/vga_timing_counter.md
VGA_TIMING_COUNTER -- requirements
Module: vga_timing_counter

Interface
REQ-001 SHALL have parameter HMAX, default 800, meaning total pixel clocks per line, including blanking.
REQ-002 SHALL have parameter VMAX, default 525, meaning total lines per frame, including blanking.
REQ-003 SHALL have parameter CLKS_PER_PIXEL, default 1, meaning i_Clk cycles per pixel; legal range 1..16.
REQ-004 SHALL have port i_Clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port i_Reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_Enable  input  1  advance enable; low freezes all counters.
REQ-007 SHALL have port o_H_count  output  $clog2(HMAX)  current pixel column; feeds the sync decoder's i_H_count.
REQ-008 SHALL have port o_V_count  output  $clog2(VMAX)  current line; feeds the sync decoder's i_V_count.
REQ-009 SHALL have port o_pix_tick  output  1  one-cycle pulse when the counts take a new value.
REQ-010 SHALL have port o_line_end  output  1  one-cycle pulse when o_H_count wraps to 0.
REQ-011 SHALL have port o_frame_end  output  1  one-cycle pulse when both counts wrap to 0.
REQ-012 SHALL have port o_frame_count  output  8  frame counter; exists only under FRAME_COUNT_EN.

Function
REQ-013 SHALL hold an internal divider, 0..CLKS_PER_PIXEL-1, that increments on each edge with i_Enable=1 and wraps to 0.
REQ-014 SHALL define an advance edge as an edge with i_Enable=1 and divider = CLKS_PER_PIXEL-1; with CLKS_PER_PIXEL=1, every enabled edge is an advance edge.
REQ-015 SHALL, on an advance edge, increment o_H_count, or set it to 0 if o_H_count = HMAX-1.
REQ-016 SHALL, on an advance edge with o_H_count = HMAX-1, increment o_V_count, or set it to 0 if o_V_count = VMAX-1; otherwise o_V_count holds.
REQ-017 SHALL register o_pix_tick high for exactly the cycle following each advance edge, coincident with the new count values; low otherwise.
REQ-018 SHALL register o_line_end high in the same cycle o_H_count first reads 0 after a wrap (not after reset).
REQ-019 SHALL register o_frame_end high in the same cycle o_H_count and o_V_count first read 0 after a wrap; o_line_end is also high that cycle.
REQ-020 SHALL freeze the divider, o_H_count and o_V_count while i_Enable=0, and drive all pulse outputs low; counting resumes from the frozen state without skipping or repeating a pixel.
REQ-021 SHALL never output o_H_count >= HMAX or o_V_count >= VMAX.
REQ-022 SHALL give all outputs one register stage of latency from state; no combinational path from inputs to outputs.

Reset
REQ-023 SHALL, on an edge with i_Reset=1, set the divider, o_H_count, o_V_count, o_pix_tick, o_line_end, o_frame_end and o_frame_count to 0, overriding i_Enable.
REQ-024 SHALL accept reset mid-line or mid-frame with no pulse emitted for the truncated line or frame.
REQ-025 SHALL emit its first advance edge CLKS_PER_PIXEL enabled cycles after the first edge with i_Reset=0.

Configuration
REQ-026 SHALL, with macro FRAME_COUNT_EN defined, include o_frame_count, which increments modulo 256 on each advance edge that sets o_frame_end.
REQ-027 SHALL, without FRAME_COUNT_EN, omit the o_frame_count port and its register; all other behaviour is unchanged.

Verification
REQ-028 SHALL check: HMAX=10, VMAX=4, CLKS_PER_PIXEL=1, enable held high -> o_line_end every 10 cycles, o_frame_end every 40 cycles, the first one 40 cycles after reset release.
REQ-029 SHALL check: CLKS_PER_PIXEL=3 -> o_pix_tick every 3rd cycle, o_H_count steps 0,1,2 at ticks, and o_frame_end every 120 cycles with HMAX=10, VMAX=4.
REQ-030 SHALL check: i_Enable low for 7 cycles at H=5, V=2 -> counts hold at 5,2, no pulses, then resume at 6,2.
REQ-031 SHALL check: i_Reset pulsed at H=8, V=3 -> next cycle H=0, V=0, all pulses 0, and no o_frame_end for that truncated frame.
REQ-032 SHALL check: default params with FRAME_COUNT_EN defined -> o_frame_end 420000 cycles apart, and o_frame_count wraps from 255 to 0 on the 256th frame.
REQ-033 SHALL check: FRAME_COUNT_EN undefined -> the build elaborates without o_frame_count and the bench of REQ-028 passes unchanged.
